// File: rtl/img_streamer_if.sv
// img_streamer_if: groups the frame write port, stream control and the
// streamed pixel bus of img_streamer.
//   master : frame writer / stream consumer (drives wr_*, start, stall)
//   slave  : img_streamer itself (drives pixel_out, flags, busy, done)
interface img_streamer_if #(
   parameter int IMG_WIDTH  = 5,
   parameter int IMG_HEIGHT = 5,
   parameter int PIX_W      = 8
);
   localparam int N  = IMG_WIDTH * IMG_HEIGHT;
   localparam int AW = $clog2(N);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [PIX_W-1:0] wr_data;
   logic             start;
   logic             stall;
   logic [PIX_W-1:0] pixel_out;
   logic             pixel_valid;
   logic [RW-1:0]    row;
   logic [CW-1:0]    col;
   logic             sof;
   logic             eol;
   logic             eof;
   logic             busy;
   logic             done;

   modport master (
      output wr_en, wr_addr, wr_data, start, stall,
      input  pixel_out, pixel_valid, row, col, sof, eol, eof, busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start, stall,
      output pixel_out, pixel_valid, row, col, sof, eol, eof, busy, done
   );
endinterface

// File: rtl/img_streamer.sv
// img_streamer: holds one IMG_WIDTH x IMG_HEIGHT frame and, on start, replays
// it in raster order (one pixel per unstalled cycle) with frame/line markers.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - img_streamer_if.slave: write port (wr_en/wr_addr/wr_data),
//          control (start/stall), stream out (pixel_out, pixel_valid, row,
//          col, sof, eol, eof), status (busy, done)
module img_streamer #(
   parameter int IMG_WIDTH  = 5,
   parameter int IMG_HEIGHT = 5,
   parameter int PIX_W      = 8
) (
   input  logic          clk,
   input  logic          rst,
   img_streamer_if.slave bus
);
   localparam int N  = IMG_WIDTH * IMG_HEIGHT;
   localparam int AW = $clog2(N);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

   state_t state_q, state_d;

   logic [PIX_W-1:0] mem [N];
   logic [AW-1:0]    idx;
   logic [RW-1:0]    row_cnt;
   logic [CW-1:0]    col_cnt;

   logic [PIX_W-1:0] pixel_q;
   logic             valid_q, sof_q, eol_q, eof_q, busy_q, done_q;
   logic [RW-1:0]    row_q;
   logic [CW-1:0]    col_q;

   logic last_px, last_col;

   assign last_px  = (idx == AW'(N - 1));
   assign last_col = (col_cnt == CW'(IMG_WIDTH - 1));

   // Frame storage is deliberately not reset; writes only land while idle.
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && bus.wr_en && int'(bus.wr_addr) < N)
         mem[bus.wr_addr] <= bus.wr_data;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (bus.start) state_d = S_STREAM;
         S_STREAM: if (!bus.stall && last_px) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx     <= '0;
         row_cnt <= '0;
         col_cnt <= '0;
         pixel_q <= '0;
         valid_q <= 1'b0;
         row_q   <= '0;
         col_q   <= '0;
         sof_q   <= 1'b0;
         eol_q   <= 1'b0;
         eof_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         // Markers are single-cycle; they only rise on an issued pixel.
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         eol_q   <= 1'b0;
         eof_q   <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  idx     <= '0;
                  row_cnt <= '0;
                  col_cnt <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_STREAM: begin
               // On stall pixel/row/col keep their last values, idx holds.
               if (!bus.stall) begin
                  pixel_q <= mem[idx];
                  valid_q <= 1'b1;
                  row_q   <= row_cnt;
                  col_q   <= col_cnt;
                  sof_q   <= (idx == '0);
                  eol_q   <= last_col;
                  eof_q   <= last_px;
                  idx     <= idx + 1'b1;
                  if (last_col) begin
                     col_cnt <= '0;
                     row_cnt <= row_cnt + 1'b1;
                  end else begin
                     col_cnt <= col_cnt + 1'b1;
                  end
               end
            end
            S_DONE: begin
               done_q <= 1'b1;
               busy_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.pixel_out   = pixel_q;
   assign bus.pixel_valid = valid_q;
   assign bus.row         = row_q;
   assign bus.col         = col_q;
   assign bus.sof         = sof_q;
   assign bus.eol         = eol_q;
   assign bus.eof         = eof_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
endmodule

// File: tb/tb_img_streamer.sv
// tb_img_streamer: directed bench for img_streamer (5x5 frame, 8-bit pixels).
module tb_img_streamer;
   localparam int W  = 5;
   localparam int H  = 5;
   localparam int PW = 8;
   localparam int AW = $clog2(W * H);

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   img_streamer_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) bus ();

   img_streamer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Observations of one streamed frame, filled by collect().
   int pix_q[$], row_q[$], col_q[$], sof_q[$], eol_q[$], eof_q[$];
   int first_at, gap_cnt, done_dist, done_cnt, hold_err, busy_at_done;
   bit timeout;

   task automatic write_frame();
      for (int i = 0; i < W * H; i++) begin
         @(negedge clk);
         bus.wr_en   = 1'b1;
         bus.wr_addr = AW'(i);
         bus.wr_data = PW'(i + 1);
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   // Pulse start, then watch the stream at each falling edge. stall_at: after
   // that many pixels raise stall for stall_len cycles. poke_at: after that many
   // pixels re-pulse start and try a write of 8'hFF to address 0.
   task automatic collect(input int stall_at, input int stall_len, input int poke_at);
      int c, stall_left, last_pix, eof_c;
      pix_q.delete(); row_q.delete(); col_q.delete();
      sof_q.delete(); eol_q.delete(); eof_q.delete();
      first_at = -1; gap_cnt = 0; done_dist = -1; done_cnt = 0;
      hold_err = 0; busy_at_done = -1; timeout = 1'b0;
      stall_left = 0; last_pix = -1; eof_c = -1;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      c = 0;
      while (1) begin
         if (bus.pixel_valid) begin
            if (first_at < 0) first_at = c;
            pix_q.push_back(int'(bus.pixel_out));
            row_q.push_back(int'(bus.row));
            col_q.push_back(int'(bus.col));
            if (bus.sof) sof_q.push_back(int'(bus.pixel_out));
            if (bus.eol) eol_q.push_back(int'(bus.pixel_out));
            if (bus.eof) begin eof_q.push_back(int'(bus.pixel_out)); eof_c = c; end
            last_pix = int'(bus.pixel_out);
         end else if (first_at >= 0 && eof_c < 0) begin
            gap_cnt++;
            if (int'(bus.pixel_out) != last_pix) hold_err++;
         end
         if (bus.done) begin
            done_cnt++;
            if (done_dist < 0 && eof_c >= 0) done_dist = c - eof_c;
            busy_at_done = int'(bus.busy);
         end
         bus.stall = 1'b0; bus.start = 1'b0; bus.wr_en = 1'b0;
         if (stall_left > 0) begin bus.stall = 1'b1; stall_left--; end
         if (bus.pixel_valid && pix_q.size() == stall_at) begin
            bus.stall = 1'b1; stall_left = stall_len - 1;
         end
         if (bus.pixel_valid && pix_q.size() == poke_at) begin
            bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = 8'hFF;
         end
         if (eof_c >= 0 && c >= eof_c + 4) break;
         if (c >= 200) begin timeout = 1'b1; break; end
         @(negedge clk);
         c++;
      end
      bus.stall = 1'b0; bus.start = 1'b0; bus.wr_en = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      nvec++; if (bus.pixel_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%b exp=0", bus.pixel_valid); end
      nvec++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      nvec++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      nvec++; if ({bus.sof, bus.eol, bus.eof} !== 3'b000) begin nerr++; $display("FAIL reset_flags got=%b exp=000", {bus.sof, bus.eol, bus.eof}); end
      nvec++; if (bus.pixel_out !== '0 || bus.row !== '0 || bus.col !== '0) begin
         nerr++; $display("FAIL reset_data got pix=%0d row=%0d col=%0d exp=0", bus.pixel_out, bus.row, bus.col);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int exp_eol[5] = '{5, 10, 15, 20, 25};
      write_frame();
      collect(-1, 0, -1);
      nvec++; if (timeout) begin nerr++; $display("FAIL basic_timeout got=no_eof exp=eof"); end
      nvec++; if (pix_q.size() != 25) begin nerr++; $display("FAIL basic_count got=%0d exp=25", pix_q.size()); end
      for (int i = 0; i < 25 && i < pix_q.size(); i++) begin
         nvec++;
         if (pix_q[i] != i + 1 || row_q[i] != i / W || col_q[i] != i % W) begin
            nerr++; $display("FAIL basic_pix[%0d] got pix=%0d row=%0d col=%0d exp pix=%0d row=%0d col=%0d",
                             i, pix_q[i], row_q[i], col_q[i], i + 1, i / W, i % W);
         end
      end
      nvec++; if (sof_q.size() != 1 || sof_q[0] != 1) begin nerr++; $display("FAIL basic_sof got n=%0d exp=1 on pixel 1", sof_q.size()); end
      nvec++; if (eol_q.size() != 5) begin nerr++; $display("FAIL basic_eol_count got=%0d exp=5", eol_q.size()); end
      for (int k = 0; k < 5 && k < eol_q.size(); k++) begin
         nvec++; if (eol_q[k] != exp_eol[k]) begin nerr++; $display("FAIL basic_eol[%0d] got=%0d exp=%0d", k, eol_q[k], exp_eol[k]); end
      end
      nvec++; if (eof_q.size() != 1 || eof_q[0] != 25) begin nerr++; $display("FAIL basic_eof got n=%0d exp=1 on pixel 25", eof_q.size()); end
      nvec++; if (first_at != 1) begin nerr++; $display("FAIL basic_latency got=%0d exp=1", first_at); end
      nvec++; if (gap_cnt != 0) begin nerr++; $display("FAIL basic_gaps got=%0d exp=0", gap_cnt); end
      nvec++; if (done_dist != 1) begin nerr++; $display("FAIL basic_done_dist got=%0d exp=1", done_dist); end
      nvec++; if (done_cnt != 1) begin nerr++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
      nvec++; if (busy_at_done != 0) begin nerr++; $display("FAIL basic_busy_at_done got=%0d exp=0", busy_at_done); end
   endtask

   task automatic test_stall();
      collect(7, 3, -1);
      nvec++; if (pix_q.size() != 25) begin nerr++; $display("FAIL stall_count got=%0d exp=25", pix_q.size()); end
      for (int i = 0; i < 25 && i < pix_q.size(); i++) begin
         nvec++; if (pix_q[i] != i + 1) begin nerr++; $display("FAIL stall_pix[%0d] got=%0d exp=%0d", i, pix_q[i], i + 1); end
      end
      nvec++; if (gap_cnt != 3) begin nerr++; $display("FAIL stall_gaps got=%0d exp=3", gap_cnt); end
      nvec++; if (hold_err != 0) begin nerr++; $display("FAIL stall_hold got=%0d exp=0", hold_err); end
      nvec++; if (eof_q.size() != 1 || eof_q[0] != 25) begin nerr++; $display("FAIL stall_eof got n=%0d exp=1 on pixel 25", eof_q.size()); end
      nvec++; if (done_dist != 1) begin nerr++; $display("FAIL stall_done_dist got=%0d exp=1", done_dist); end
   endtask

   task automatic test_busy_ignore();
      collect(-1, 0, 10);
      nvec++; if (pix_q.size() != 25) begin nerr++; $display("FAIL busy_count got=%0d exp=25", pix_q.size()); end
      for (int i = 0; i < 25 && i < pix_q.size(); i++) begin
         nvec++; if (pix_q[i] != i + 1) begin nerr++; $display("FAIL busy_pix[%0d] got=%0d exp=%0d", i, pix_q[i], i + 1); end
      end
      nvec++; if (done_cnt != 1) begin nerr++; $display("FAIL busy_done_cnt got=%0d exp=1", done_cnt); end
      collect(-1, 0, -1);
      nvec++; if (pix_q.size() != 25) begin nerr++; $display("FAIL replay_count got=%0d exp=25", pix_q.size()); end
      for (int i = 0; i < 25 && i < pix_q.size(); i++) begin
         nvec++; if (pix_q[i] != i + 1) begin nerr++; $display("FAIL replay_pix[%0d] got=%0d exp=%0d", i, pix_q[i], i + 1); end
      end
   endtask

   task automatic test_bad_addr();
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_addr = AW'(25); bus.wr_data = 8'hAA;
      @(negedge clk);
      bus.wr_en = 1'b0;
      collect(-1, 0, -1);
      nvec++; if (pix_q.size() != 25) begin nerr++; $display("FAIL badaddr_count got=%0d exp=25", pix_q.size()); end
      for (int i = 0; i < 25 && i < pix_q.size(); i++) begin
         nvec++; if (pix_q[i] != i + 1) begin nerr++; $display("FAIL badaddr_pix[%0d] got=%0d exp=%0d", i, pix_q[i], i + 1); end
      end
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int c = 0; c < 60 && !seen; c++) begin
         @(negedge clk);
         if (bus.pixel_valid && bus.pixel_out == 8'd12) seen = 1'b1;
      end
      nvec++; if (!seen) begin nerr++; $display("FAIL rstmid_reach got=no_pixel12 exp=pixel12"); end
      rst = 1'b1;
      #1;
      nvec++; if (bus.pixel_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         nerr++; $display("FAIL rstmid_clear got valid=%b busy=%b done=%b exp=0", bus.pixel_valid, bus.busy, bus.done);
      end
      @(negedge clk);
      rst = 1'b0;
      collect(-1, 0, -1);
      nvec++; if (pix_q.size() != 25) begin nerr++; $display("FAIL rstmid_count got=%0d exp=25", pix_q.size()); end
      for (int i = 0; i < 25 && i < pix_q.size(); i++) begin
         nvec++; if (pix_q[i] != i + 1) begin nerr++; $display("FAIL rstmid_pix[%0d] got=%0d exp=%0d", i, pix_q[i], i + 1); end
      end
      nvec++; if (sof_q.size() != 1 || sof_q[0] != 1) begin nerr++; $display("FAIL rstmid_sof got n=%0d exp=1 on pixel 1", sof_q.size()); end
   endtask

   task automatic test_eof_stall();
      collect(24, 2, -1);
      nvec++; if (pix_q.size() != 25) begin nerr++; $display("FAIL eofstall_count got=%0d exp=25", pix_q.size()); end
      for (int i = 0; i < 25 && i < pix_q.size(); i++) begin
         nvec++; if (pix_q[i] != i + 1) begin nerr++; $display("FAIL eofstall_pix[%0d] got=%0d exp=%0d", i, pix_q[i], i + 1); end
      end
      nvec++; if (gap_cnt != 2) begin nerr++; $display("FAIL eofstall_gaps got=%0d exp=2", gap_cnt); end
      nvec++; if (eof_q.size() != 1 || eof_q[0] != 25) begin nerr++; $display("FAIL eofstall_eof got n=%0d exp=1 on pixel 25", eof_q.size()); end
      nvec++; if (done_dist != 1) begin nerr++; $display("FAIL eofstall_done_dist got=%0d exp=1", done_dist); end
      nvec++; if (done_cnt != 1) begin nerr++; $display("FAIL eofstall_done_cnt got=%0d exp=1", done_cnt); end
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.start = 1'b0; bus.stall = 1'b0;
      test_reset();
      test_basic();
      test_stall();
      test_busy_ignore();
      test_bad_addr();
      test_reset_mid();
      test_eof_stall();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
